program_sequencer: RTL
======================

Name: program_sequencer

Overview:
- Upstream neighbour of the instruction decoder. It generates the program-memory address every cycle from the decoder's jump controls and the ALU zero flag.
- Program memory is synchronous. pm_addr is presented combinationally, and the fetched byte arrives as next_instr one cycle later.
- Also keeps a 4-entry taken-jump trace and a saturating taken-jump counter, readable through a debug/exam port (from_PS).

Parameters:
- RESET_ADDR, 8'h00, address fetched while reset is asserted and the restart point after reset.
- TRACE_DEPTH, 4, number of taken-jump source PCs retained. Fixed at 4 in this revision; dbg_sel is sized for it.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- sync_reset_n  input  1  reset, active-low, synchronous to clk
- jmp  input  1  unconditional jump request from decoder
- jmp_nz  input  1  conditional jump request; taken when dont_jmp=0
- jmp_addr  input  4  jump target nibble (decoder ir_nibble)
- dont_jmp  input  1  ALU zero flag; 1 suppresses a conditional jump
- hold  input  1  stall: re-fetch current pc, no state change except counters unaffected
- dbg_sel  input  3  debug select: 0-3 = trace entry (0 most recent), 4 = jump counter, 5-7 = pc
- pm_addr  output  8  next program-memory address (combinational)
- pc  output  8  registered address of instruction now being fetched
- jump_taken  output  1  combinational: this cycle's pm_addr comes from a jump
- from_PS  output  8  debug/exam value selected by dbg_sel

Behaviour:
Interface:
- One clock; reset is synchronous and active-low.
- sync_reset_n=0 is sampled only at the rising edge of clk. No asynchronous path.

pm_addr priority, evaluated combinationally each cycle:
1. sync_reset_n=0 -> RESET_ADDR.
2. hold=1 -> pc.
3. jmp=1 -> {jmp_addr, 4'h0}.
4. jmp_nz=1 & dont_jmp=0 -> {jmp_addr, 4'h0}.
5. Otherwise pc+1, 8-bit modulo: 8'hFF wraps to 8'h00 with no flag.

Jump and registered state:
- jmp=1 and jmp_nz=1 together (decoder's JUMP_NEXT case): rule 3 wins; the jump is unconditional regardless of dont_jmp.
- jump_taken = (rule 3 or rule 4 selected) & sync_reset_n & ~hold.
- pc <= pm_addr every rising edge, including during hold, where the value is unchanged.
- Reset values, applied on the edge with sync_reset_n=0:
  - pc = RESET_ADDR
  - all trace entries = 8'h00
  - trace write pointer = 0
  - jump counter = 0
  - pm_addr = RESET_ADDR during reset
  - jump_taken = 0 during reset
  - from_PS reflects the cleared state

Trace buffer:
- On an edge where jump_taken=1, the current pc (source address of the jump instruction) is written at the write pointer.
- The write pointer then increments modulo 4, overwriting the oldest entry.
- Read index = (wr_ptr - 1 - dbg_sel[1:0]) mod 4, so dbg_sel=0 returns the most recent jump.
- Entries never written read 8'h00.

Jump counter:
- 8-bit, increments on each edge with jump_taken=1.
- Saturates at 8'hFF; no wrap.

Debug output:
- from_PS is combinational from registers only; it has no path from the jump inputs.

Simultaneous events:
- Reset beats hold, which beats any jump. A jump requested during hold is dropped, not deferred; the decoder re-presents it since ir is re-fetched.
- Reset asserted mid-run clears trace and counter on that same edge.

Decomposition:
- Add to shared package defs:
  - RESET_ADDR default constant
  - TRACE_DEPTH
  - dbg_sel encodings (DBG_TRACE0..3, DBG_JCOUNT, DBG_PC)
  - an enum next_src_t {SRC_RESET, SRC_HOLD, SRC_JMP, SRC_JNZ, SRC_INC} for the address mux
- One sub-module: jump_trace_buffer, containing the 4x8 circular store, write pointer, relative-index read and saturating counter.
  - Inputs: clk, sync_reset_n, wr_en, wr_data, rd_sel.
  - Outputs: rd_data, jcount.
- Top level holds pc, the next-address mux and the from_PS mux.

Test Plan:
1. Reset, then 3 free cycles -> pm_addr sequence 00,01,02,03; pc lags one cycle; from_PS with dbg_sel=4 reads 00.
2. pc=8'h2A, jmp=1, jmp_addr=4'h7 -> pm_addr=8'h70, jump_taken=1; next cycle pc=70, trace0=2A, counter=1.
3. jmp_nz=1, jmp_addr=4'h3: with dont_jmp=1 -> pm_addr=pc+1, counter unchanged; with dont_jmp=0 -> pm_addr=8'h30. Then jmp=jmp_nz=1 with dont_jmp=1 -> pm_addr={nibble,0}.
4. pc=8'hFF, no jump -> pm_addr=8'h00; hold=1 at pc=8'h10 with jmp=1 -> pm_addr=8'h10, jump_taken=0, counter/trace unchanged.
5. Take 5 jumps from pcs 01,02,03,04,05 -> dbg_sel 0..3 read 05,04,03,02; then 300 more jumps -> dbg_sel=4 reads FF.
6. Assert sync_reset_n=0 for one edge mid-run with jmp=1 -> pm_addr=00 during reset, pc=00 after, all trace entries and counter read 00.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
// rtl/program_sequencer_pkg.sv - shared constants and types for the program sequencer
package program_sequencer_pkg;

  localparam logic [7:0] RESET_ADDR_DEF = 8'h00;
  localparam int         TRACE_DEPTH    = 4;

  localparam logic [2:0] DBG_TRACE0 = 3'd0;
  localparam logic [2:0] DBG_TRACE1 = 3'd1;
  localparam logic [2:0] DBG_TRACE2 = 3'd2;
  localparam logic [2:0] DBG_TRACE3 = 3'd3;
  localparam logic [2:0] DBG_JCOUNT = 3'd4;
  localparam logic [2:0] DBG_PC     = 3'd5;

  typedef enum logic [2:0] {
    SRC_RESET,
    SRC_HOLD,
    SRC_JMP,
    SRC_JNZ,
    SRC_INC
  } next_src_t;

endpackage

// File: rtl/jump_trace_buffer.sv
// rtl/jump_trace_buffer.sv - circular store of taken-jump source PCs plus saturating jump counter
module jump_trace_buffer
  import program_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       sync_reset_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic [1:0] rd_sel,
  output logic [7:0] rd_data,
  output logic [7:0] jcount
);

  logic [7:0] store [TRACE_DEPTH];
  logic [1:0] wr_ptr;
  logic [1:0] rd_idx;

  // Record the jump source, advance the pointer and bump the counter (saturating at FF)
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      for (int i = 0; i < TRACE_DEPTH; i++) begin
        store[i] <= 8'h00;
      end
      wr_ptr <= 2'd0;
      jcount <= 8'h00;
    end else if (wr_en) begin
      store[wr_ptr] <= wr_data;
      wr_ptr        <= wr_ptr + 2'd1;
      if (jcount != 8'hFF) begin
        jcount <= jcount + 8'd1;
      end
    end
  end

  // Read relative to the newest entry; 2-bit arithmetic gives the modulo-4 wrap
  always_comb begin
    rd_idx  = wr_ptr - 2'd1 - rd_sel;
    rd_data = store[rd_idx];
  end

endmodule

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - program-memory address generator with jump trace debug port
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter logic [7:0] RESET_ADDR = RESET_ADDR_DEF
) (
  input  logic       clk,
  input  logic       sync_reset_n,
  input  logic       jmp,
  input  logic       jmp_nz,
  input  logic [3:0] jmp_addr,
  input  logic       dont_jmp,
  input  logic       hold,
  input  logic [2:0] dbg_sel,
  output logic [7:0] pm_addr,
  output logic [7:0] pc,
  output logic       jump_taken,
  output logic [7:0] from_PS
);

  next_src_t  next_src;
  logic [7:0] trace_data;
  logic [7:0] jcount;

  // Next-address source: reset beats hold beats unconditional jump beats conditional jump
  always_comb begin
    next_src = SRC_INC;
    if (!sync_reset_n) begin
      next_src = SRC_RESET;
    end else if (hold) begin
      next_src = SRC_HOLD;
    end else if (jmp) begin
      next_src = SRC_JMP;
    end else if (jmp_nz && !dont_jmp) begin
      next_src = SRC_JNZ;
    end
  end

  // Address mux; jump_taken already excludes reset and hold via the source priority
  always_comb begin
    pm_addr    = pc + 8'd1;
    jump_taken = 1'b0;
    case (next_src)
      SRC_RESET: pm_addr = RESET_ADDR;
      SRC_HOLD:  pm_addr = pc;
      SRC_JMP, SRC_JNZ: begin
        pm_addr    = {jmp_addr, 4'h0};
        jump_taken = 1'b1;
      end
      default:   pm_addr = pc + 8'd1;
    endcase
  end

  // pc tracks the address presented to program memory on the previous cycle
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      pc <= RESET_ADDR;
    end else begin
      pc <= pm_addr;
    end
  end

  jump_trace_buffer u_trace (
    .clk          (clk),
    .sync_reset_n (sync_reset_n),
    .wr_en        (jump_taken),
    .wr_data      (pc),
    .rd_sel       (dbg_sel[1:0]),
    .rd_data      (trace_data),
    .jcount       (jcount)
  );

  // Debug readback comes only from registered state
  always_comb begin
    from_PS = pc;
    if (dbg_sel <= DBG_TRACE3) begin
      from_PS = trace_data;
    end else if (dbg_sel == DBG_JCOUNT) begin
      from_PS = jcount;
    end
  end

endmodule
